write_arbiter: RTL and testbench
================================

WRITE_ARBITER -- requirements
Module: write_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000, max clock cycles allowed between consecutive data bytes of one write.
REQ-002 CLK_I  in  1  sole clock, all state updates on rising edge.
REQ-003 RST_NI  in  1  reset, asynchronous assert, active-low.
REQ-004 WRITE_ARBITER_VALID_I  in  1  command valid from decoder.
REQ-005 WRITE_ARBITER_READY_O  out  1  arbiter can accept a command.
REQ-006 WRITE_COMMAND_I  in  CMDLENGTH  command (CMD_WRITE or CMD_RESET).
REQ-007 WRITE_ADDRESS_I  in  IRLENGTH  target DTM register address.
REQ-008 READ_I  in  1  one-cycle strobe, UART byte available.
REQ-009 CMD_REC_I  in  1  qualifies READ_I byte as a command byte.
REQ-010 DATA_REC_I  in  8  received UART byte.
REQ-011 DTM_WRITE_VALID_O  out  1  register write request to DTM.
REQ-012 DTM_WRITE_READY_I  in  1  DTM accepts write.
REQ-013 DTM_WRITE_ADDRESS_O  out  IRLENGTH  write target address.
REQ-014 DTM_WRITE_DATA_O  out  MAX_WRITE_BYTES*8  assembled write data.
REQ-015 DTM_RESET_O  out  1  one-cycle DTM reset pulse.
REQ-016 ERROR_O  out  1  one-cycle pulse on abort, timeout or unwritable address.

Function
REQ-017 States IDLE, COLLECT, ISSUE; WRITE_ARBITER_READY_O high exactly in IDLE, driven from state only, no combinational path from inputs.
REQ-018 Command handshake completes on cycle with WRITE_ARBITER_VALID_I and WRITE_ARBITER_READY_O both high.
REQ-019 IDLE, CMD_WRITE accepted, write_length(WRITE_ADDRESS_I)>0: latch address, clear data register and byte counter, reload timeout, go COLLECT.
REQ-020 IDLE, CMD_WRITE accepted, write_length=0 (e.g. ADDR_IDCODE): ERROR_O pulse next cycle, stay IDLE.
REQ-021 IDLE, CMD_RESET accepted: DTM_RESET_O pulse next cycle, stay IDLE; any other command accepted and ignored.
REQ-022 IDLE, data bytes (READ_I=1, CMD_REC_I=0) ignored.
REQ-023 COLLECT, data byte: stored little-endian at bits [8*cnt+7:8*cnt], cnt increments, timeout reloads.
REQ-024 COLLECT, byte with cnt = length-1: go ISSUE; DTM_WRITE_VALID_O high the following cycle (1-cycle latency).
REQ-025 Bits above 8*length in DTM_WRITE_DATA_O SHALL be zero.
REQ-026 COLLECT, command byte (READ_I=1, CMD_REC_I=1): discard partial data, ERROR_O pulse, go IDLE.
REQ-027 COLLECT, timeout counter reaches zero without a byte: ERROR_O pulse, go IDLE; byte arriving on expiry cycle takes priority over timeout.
REQ-028 ISSUE: DTM_WRITE_VALID_O high, address/data held stable until DTM_WRITE_READY_I; on handshake go IDLE, valid low next cycle.
REQ-029 ISSUE: UART bytes and commands ignored; no timeout applies.
REQ-030 DTM_RESET_O and ERROR_O never high more than one consecutive cycle.

Reset
REQ-031 RST_NI low: state IDLE, counters zero, all outputs zero except WRITE_ARBITER_READY_O, which follows IDLE (1) once reset released; DTM_WRITE_ADDRESS_O, DTM_WRITE_DATA_O zero.
REQ-032 Reset mid-COLLECT or mid-ISSUE discards pending write without DTM_WRITE_VALID_O or ERROR_O.

Structure
REQ-033 uart_pkg SHALL hold CMDLENGTH, IRLENGTH, CMD_*, ADDR_* constants, MAX_WRITE_BYTES=6 and function write_length: ADDR_DTMCS->4, ADDR_DMI->6 (41-bit DMI), others->0.
REQ-034 State enum in uart_pkg; timeout counter as sub-module timeout_counter (load, tick, expired).

Verification
REQ-035 CMD_WRITE to ADDR_DTMCS, bytes 0x11,0x22,0x33,0x44 -> DTM_WRITE_DATA_O=0x000044332211, valid one cycle after last byte, address ADDR_DTMCS.
REQ-036 CMD_WRITE to ADDR_DMI, six bytes, DTM_WRITE_READY_I low 5 cycles -> valid and data held stable 5 cycles, IDLE after ready.
REQ-037 CMD_WRITE to ADDR_DMI, two bytes then command byte -> ERROR_O single pulse, no DTM write, READY_O high next cycle.
REQ-038 TIMEOUT_CYCLES=16, one byte then silence -> ERROR_O pulse 16 cycles after that byte, return to IDLE.
REQ-039 CMD_RESET accepted -> DTM_RESET_O one-cycle pulse; CMD_WRITE to ADDR_IDCODE -> ERROR_O pulse, no COLLECT.
REQ-040 RST_NI asserted during COLLECT after 3 bytes -> immediate IDLE, outputs zero, no write issued.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers for the UART-to-DTM write path.
package uart_pkg;

  localparam int CMDLENGTH       = 4;
  localparam int IRLENGTH        = 5;
  localparam int MAX_WRITE_BYTES = 6;
  localparam int DATA_WIDTH      = MAX_WRITE_BYTES * 8;
  localparam int LEN_WIDTH       = 3;

  localparam logic [CMDLENGTH-1:0] CMD_READ  = 4'h1;
  localparam logic [CMDLENGTH-1:0] CMD_WRITE = 4'h2;
  localparam logic [CMDLENGTH-1:0] CMD_RESET = 4'h3;

  localparam logic [IRLENGTH-1:0] ADDR_IDCODE = 5'h01;
  localparam logic [IRLENGTH-1:0] ADDR_DTMCS  = 5'h10;
  localparam logic [IRLENGTH-1:0] ADDR_DMI    = 5'h11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2
  } arb_state_t;

  // Number of payload bytes a DTM register takes; zero marks it read-only.
  // DMI is 41 bits wide, so it needs six bytes.
  function automatic logic [LEN_WIDTH-1:0] write_length(input logic [IRLENGTH-1:0] addr);
    case (addr)
      ADDR_DTMCS: return 3'd4;
      ADDR_DMI:   return 3'd6;
      default:    return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Down-counter that flags when too many cycles pass without a reload.
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expired
);

  // Loading TIMEOUT_CYCLES-1 makes expiry fall on the cycle the caller must act on,
  // so the abort lands exactly TIMEOUT_CYCLES clocks after the last reload.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  // Reload on demand, otherwise count down while ticking and saturate at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= LOAD_VALUE;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/write_arbiter.sv
// Gathers UART payload bytes for a write command and hands one register write to the DTM.
module write_arbiter
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  CLK_I,
  input  logic                  RST_NI,
  input  logic                  WRITE_ARBITER_VALID_I,
  output logic                  WRITE_ARBITER_READY_O,
  input  logic [CMDLENGTH-1:0]  WRITE_COMMAND_I,
  input  logic [IRLENGTH-1:0]   WRITE_ADDRESS_I,
  input  logic                  READ_I,
  input  logic                  CMD_REC_I,
  input  logic [7:0]            DATA_REC_I,
  output logic                  DTM_WRITE_VALID_O,
  input  logic                  DTM_WRITE_READY_I,
  output logic [IRLENGTH-1:0]   DTM_WRITE_ADDRESS_O,
  output logic [DATA_WIDTH-1:0] DTM_WRITE_DATA_O,
  output logic                  DTM_RESET_O,
  output logic                  ERROR_O
);

  arb_state_t            state_q, state_d;
  logic [IRLENGTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  error_q, dtm_reset_q;

  logic                  cmd_fire;
  logic                  start_write, store_byte, abort;
  logic                  error_set, reset_set;
  logic                  tmo_expired;
  logic [LEN_WIDTH-1:0]  cmd_len, wr_len;

  assign cmd_fire = WRITE_ARBITER_VALID_I && WRITE_ARBITER_READY_O;
  assign cmd_len  = write_length(WRITE_ADDRESS_I);
  assign wr_len   = write_length(addr_q);

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (CLK_I),
    .rst_n  (RST_NI),
    .load   (start_write || store_byte),
    .tick   (state_q == COLLECT),
    .expired(tmo_expired)
  );

  // State register.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; a byte arriving on the expiry cycle beats the timeout.
  always_comb begin
    state_d     = state_q;
    start_write = 1'b0;
    store_byte  = 1'b0;
    abort       = 1'b0;
    error_set   = 1'b0;
    reset_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (WRITE_COMMAND_I == CMD_WRITE) begin
            if (cmd_len != 3'd0) begin
              start_write = 1'b1;
              state_d     = COLLECT;
            end else begin
              error_set = 1'b1;
            end
          end else if (WRITE_COMMAND_I == CMD_RESET) begin
            reset_set = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (READ_I && CMD_REC_I) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (READ_I) begin
          store_byte = 1'b1;
          if (cnt_q == (wr_len - 3'd1)) begin
            state_d = ISSUE;
          end
        end else if (tmo_expired) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (DTM_WRITE_READY_I) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address latch and little-endian byte assembly; clearing on start keeps unused upper bytes zero.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (start_write) begin
      addr_q <= WRITE_ADDRESS_I;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (abort) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (store_byte) begin
      for (int i = 0; i < MAX_WRITE_BYTES; i++) begin
        if (cnt_q == LEN_WIDTH'(i)) begin
          data_q[8*i +: 8] <= DATA_REC_I;
        end
      end
      cnt_q <= cnt_q + 3'd1;
    end
  end

  // Registered single-cycle pulses; a request landing on a pulse cycle merges into it
  // so neither output is ever high two cycles in a row.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      error_q     <= 1'b0;
      dtm_reset_q <= 1'b0;
    end else begin
      error_q     <= (error_set || abort) && !error_q;
      dtm_reset_q <= reset_set && !dtm_reset_q;
    end
  end

  assign WRITE_ARBITER_READY_O = (state_q == IDLE);
  assign DTM_WRITE_VALID_O     = (state_q == ISSUE);
  assign DTM_WRITE_ADDRESS_O   = addr_q;
  assign DTM_WRITE_DATA_O      = data_q;
  assign DTM_RESET_O           = dtm_reset_q;
  assign ERROR_O               = error_q;

endmodule

// File: tb/tb_write_arbiter.sv
// Scoreboard bench for write_arbiter: directed command/byte sequences, monitor checks DTM events.
module tb_write_arbiter;
  import uart_pkg::*;

  localparam int TMO = 16;

  logic                  clk;
  logic                  rst_n;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CMDLENGTH-1:0]  cmd;
  logic [IRLENGTH-1:0]   cmd_addr;
  logic                  read_strobe;
  logic                  cmd_rec;
  logic [7:0]            data_rec;
  logic                  dtm_valid;
  logic                  dtm_ready;
  logic [IRLENGTH-1:0]   dtm_addr;
  logic [DATA_WIDTH-1:0] dtm_data;
  logic                  dtm_reset;
  logic                  error;

  int assertions = 0;
  int failures   = 0;

  typedef enum int {EV_WRITE = 0, EV_ERROR = 1, EV_RESET = 2} ev_kind_t;
  typedef struct {
    ev_kind_t              kind;
    logic [IRLENGTH-1:0]   addr;
    logic [DATA_WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  write_arbiter #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK_I                (clk),
    .RST_NI               (rst_n),
    .WRITE_ARBITER_VALID_I(cmd_valid),
    .WRITE_ARBITER_READY_O(cmd_ready),
    .WRITE_COMMAND_I      (cmd),
    .WRITE_ADDRESS_I      (cmd_addr),
    .READ_I               (read_strobe),
    .CMD_REC_I            (cmd_rec),
    .DATA_REC_I           (data_rec),
    .DTM_WRITE_VALID_O    (dtm_valid),
    .DTM_WRITE_READY_I    (dtm_ready),
    .DTM_WRITE_ADDRESS_O  (dtm_addr),
    .DTM_WRITE_DATA_O     (dtm_data),
    .DTM_RESET_O          (dtm_reset),
    .ERROR_O              (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [CMDLENGTH-1:0] c, input logic [IRLENGTH-1:0] a,
                               input logic rd, input logic cr, input logic [7:0] d);
    cmd_valid   = v;
    cmd         = c;
    cmd_addr    = a;
    read_strobe = rd;
    cmd_rec     = cr;
    data_rec    = d;
    stepCycle();
    cmd_valid   = 1'b0;
    read_strobe = 1'b0;
    cmd_rec     = 1'b0;
  endtask

  task automatic sendCommand(input logic [CMDLENGTH-1:0] c, input logic [IRLENGTH-1:0] a);
    int budget = 0;
    while (!cmd_ready && budget < 20) begin
      stepCycle();
      budget++;
    end
    checkOutput("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
    applyStimulus(1'b1, c, a, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic is_cmd);
    applyStimulus(1'b0, CMD_READ, '0, 1'b1, is_cmd, b);
  endtask

  task automatic pushExp(input ev_kind_t k, input logic [IRLENGTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic scoreEvent(input ev_kind_t k, input logic [IRLENGTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      assertions++;
      failures++;
      $display("[TB] FAIL unexpected_event: actual kind=%0d expected none", k);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event_kind", 64'(k), 64'(e.kind));
      if (e.kind == EV_WRITE && k == EV_WRITE) begin
        checkOutput("write_addr", 64'(a), 64'(e.addr));
        checkOutput("write_data", 64'(d), 64'(e.data));
      end
    end
  endtask

  // Monitor: every DTM handshake, error pulse and reset pulse must match the next expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dtm_valid && dtm_ready) scoreEvent(EV_WRITE, dtm_addr, dtm_data);
      if (error)                  scoreEvent(EV_ERROR, '0, '0);
      if (dtm_reset)              scoreEvent(EV_RESET, '0, '0);
    end
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd         = '0;
    cmd_addr    = '0;
    read_strobe = 1'b0;
    cmd_rec     = 1'b0;
    data_rec    = '0;
    dtm_ready   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 64'(dtm_valid), 64'd0);
    checkOutput("rst_addr",  64'(dtm_addr),  64'd0);
    checkOutput("rst_data",  64'(dtm_data),  64'd0);
    checkOutput("rst_error", 64'(error),     64'd0);
    checkOutput("rst_dtmrst",64'(dtm_reset), 64'd0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("ready_after_reset", 64'(cmd_ready), 64'd1);

    // DTMCS write, immediate accept
    $display("[TB] DTMCS write");
    pushExp(EV_WRITE, ADDR_DTMCS, 48'h0000_4433_2211);
    sendCommand(CMD_WRITE, ADDR_DTMCS);
    checkOutput("ready_in_collect", 64'(cmd_ready), 64'd0);
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0);
    sendByte(8'h33, 1'b0);
    checkOutput("valid_before_last", 64'(dtm_valid), 64'd0);
    sendByte(8'h44, 1'b0);
    checkOutput("valid_after_last", 64'(dtm_valid), 64'd1);
    checkOutput("dtmcs_addr", 64'(dtm_addr), 64'(ADDR_DTMCS));
    checkOutput("dtmcs_data", 64'(dtm_data), 64'h0000_4433_2211);
    stepCycle();
    checkOutput("valid_dropped", 64'(dtm_valid), 64'd0);
    checkOutput("ready_back", 64'(cmd_ready), 64'd1);

    // DMI write with DTM back-pressure
    $display("[TB] DMI write with stall");
    dtm_ready = 1'b0;
    pushExp(EV_WRITE, ADDR_DMI, 48'h0605_0403_0201);
    sendCommand(CMD_WRITE, ADDR_DMI);
    for (int b = 1; b <= 6; b++) sendByte(8'(b), 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 64'(dtm_valid), 64'd1);
      checkOutput("stall_data", 64'(dtm_data), 64'h0605_0403_0201);
      checkOutput("stall_addr", 64'(dtm_addr), 64'(ADDR_DMI));
      stepCycle();
    end
    checkOutput("stall_valid_final", 64'(dtm_valid), 64'd1);
    dtm_ready = 1'b1;
    stepCycle();
    checkOutput("stall_valid_low", 64'(dtm_valid), 64'd0);
    checkOutput("stall_ready_back", 64'(cmd_ready), 64'd1);

    // Abort by command byte
    $display("[TB] abort by command byte");
    pushExp(EV_ERROR, '0, '0);
    sendCommand(CMD_WRITE, ADDR_DMI);
    sendByte(8'hAA, 1'b0);
    sendByte(8'hBB, 1'b0);
    sendByte(8'hCC, 1'b1);
    checkOutput("abort_error", 64'(error), 64'd1);
    checkOutput("abort_ready", 64'(cmd_ready), 64'd1);
    checkOutput("abort_valid", 64'(dtm_valid), 64'd0);
    stepCycle();
    checkOutput("abort_error_single", 64'(error), 64'd0);

    // Timeout after one byte
    $display("[TB] timeout");
    pushExp(EV_ERROR, '0, '0);
    sendCommand(CMD_WRITE, ADDR_DTMCS);
    sendByte(8'h55, 1'b0);
    for (int i = 1; i < TMO; i++) begin
      checkOutput("tmo_no_error_yet", 64'(error), 64'd0);
      stepCycle();
    end
    checkOutput("tmo_still_collect", 64'(cmd_ready), 64'd0);
    stepCycle();
    checkOutput("tmo_error", 64'(error), 64'd1);
    checkOutput("tmo_ready", 64'(cmd_ready), 64'd1);
    stepCycle();
    checkOutput("tmo_error_single", 64'(error), 64'd0);

    // Byte on the expiry cycle wins over the timeout
    $display("[TB] byte on expiry cycle");
    pushExp(EV_WRITE, ADDR_DTMCS, 48'h0000_0403_0201);
    sendCommand(CMD_WRITE, ADDR_DTMCS);
    sendByte(8'h01, 1'b0);
    repeat (TMO - 1) stepCycle();
    sendByte(8'h02, 1'b0);
    checkOutput("edge_no_error", 64'(error), 64'd0);
    checkOutput("edge_collecting", 64'(cmd_ready), 64'd0);
    sendByte(8'h03, 1'b0);
    sendByte(8'h04, 1'b0);
    checkOutput("edge_valid", 64'(dtm_valid), 64'd1);
    stepCycle();

    // DTM reset command and unwritable address
    $display("[TB] reset command and IDCODE write");
    pushExp(EV_RESET, '0, '0);
    sendCommand(CMD_RESET, '0);
    checkOutput("dtmrst_pulse", 64'(dtm_reset), 64'd1);
    checkOutput("dtmrst_ready", 64'(cmd_ready), 64'd1);
    stepCycle();
    checkOutput("dtmrst_single", 64'(dtm_reset), 64'd0);
    pushExp(EV_ERROR, '0, '0);
    sendCommand(CMD_WRITE, ADDR_IDCODE);
    checkOutput("idcode_error", 64'(error), 64'd1);
    checkOutput("idcode_stay_idle", 64'(cmd_ready), 64'd1);
    stepCycle();
    checkOutput("idcode_error_single", 64'(error), 64'd0);

    // Other commands and stray data bytes in IDLE are ignored
    $display("[TB] ignored inputs in IDLE");
    sendCommand(CMD_READ, ADDR_DMI);
    checkOutput("other_cmd_ready", 64'(cmd_ready), 64'd1);
    sendByte(8'h77, 1'b0);
    checkOutput("stray_byte_ready", 64'(cmd_ready), 64'd1);
    checkOutput("stray_byte_error", 64'(error), 64'd0);

    // Reset in the middle of a collection
    $display("[TB] reset during collect");
    sendCommand(CMD_WRITE, ADDR_DMI);
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 64'(dtm_valid), 64'd0);
    checkOutput("midrst_addr",  64'(dtm_addr),  64'd0);
    checkOutput("midrst_data",  64'(dtm_data),  64'd0);
    checkOutput("midrst_error", 64'(error),     64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stepCycle();
    checkOutput("midrst_ready", 64'(cmd_ready), 64'd1);
    repeat (3) stepCycle();
    checkOutput("midrst_no_write", 64'(dtm_valid), 64'd0);

    // Clean DMI write after reset
    pushExp(EV_WRITE, ADDR_DMI, 48'hA6A5_A4A3_A2A1);
    sendCommand(CMD_WRITE, ADDR_DMI);
    for (int b = 1; b <= 6; b++) sendByte(8'hA0 + 8'(b), 1'b0);
    checkOutput("post_rst_valid", 64'(dtm_valid), 64'd1);
    stepCycle();

    repeat (3) stepCycle();
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
